rr_arb_mux: RTL and testbench

//   Parametrised N:1 data selector with built-in arbitration and one registered output stage.

---
 rtl/mips_pkg.sv | 8 +
 rtl/rr_grant.sv | 32 +++
 rtl/rr_arb_mux.sv | 67 ++++++
 tb/tb_rr_arb_mux.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: arbitration mode constants and small index helpers shared by arbiters.
package mips_pkg;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  function automatic int wrap_inc(int idx, int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin / fixed-priority grant, one-hot plus binary index.
module rr_grant
  import mips_pkg::*;
#(
  parameter  int NUM_IN  = 4,
  parameter  int RR_MODE = ARB_RR,
  localparam int SEL_W   = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [NUM_IN-1:0] gnt_o,
  output logic [SEL_W-1:0]  idx_o,
  output logic              any_o
);
  logic [NUM_IN-1:0] upper;
  logic [SEL_W-1:0]  up_idx;
  logic [SEL_W-1:0]  lo_idx;
  // Requests at or above ptr win first; otherwise wrap to the lowest request.
  always_comb begin
    upper  = '0;
    up_idx = '0;
    lo_idx = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      upper[i] = req_i[i] & ((RR_MODE == ARB_FIXED) || (i >= int'(ptr_i)));
      if (req_i[i]) lo_idx = SEL_W'(i);
      if (upper[i]) up_idx = SEL_W'(i);
    end
  end
  assign any_o = |req_i;
  assign idx_o = |upper ? up_idx : lo_idx;
  assign gnt_o = any_o ? NUM_IN'(1) << idx_o : '0;
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N:1 arbitrated data selector with valid/ready handshake and one output register.
module rr_arb_mux
  import mips_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int NUM_IN  = 4,
  parameter  int RR_MODE = ARB_RR,
  localparam int SEL_W   = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [NUM_IN-1:0] gnt_oh;
  logic [SEL_W-1:0]  gnt_idx;
  logic              any_req;
  logic              load;
  logic              fire;

  rr_grant #(.NUM_IN(NUM_IN), .RR_MODE(RR_MODE)) u_grant (
    .req_i (in_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt_oh),
    .idx_o (gnt_idx),
    .any_o (any_req)
  );

  assign load     = ~out_valid_q | out_ready;
  assign fire     = load & any_req;
  // rst_n gates ready so no upstream beat is consumed while held in reset.
  assign in_ready = (load & rst_n) ? gnt_oh : '0;

  always_comb begin
    out_valid_d = load ? any_req : out_valid_q;
    out_data_d  = fire ? in_data[int'(gnt_idx)*WIDTH +: WIDTH] : out_data_q;
    out_sel_d   = fire ? gnt_idx : out_sel_q;
    ptr_d       = (fire && RR_MODE == ARB_RR) ? SEL_W'(wrap_inc(int'(gnt_idx), NUM_IN)) : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed vector bench for round-robin, fixed-priority and 3-channel arbiters.
module tb_rr_arb_mux;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]   v4, r4o;
  logic [127:0] d4;
  logic         r4, ov4;
  logic [31:0]  od4;
  logic [1:0]   s4;

  logic [3:0]   vf, rfo;
  logic [127:0] df;
  logic         rf, ovf;
  logic [31:0]  odf;
  logic [1:0]   sf;

  logic [2:0]   v3, r3o;
  logic [95:0]  d3;
  logic         r3, ov3;
  logic [31:0]  od3;
  logic [1:0]   s3;

  rr_arb_mux #(.WIDTH(32), .NUM_IN(4), .RR_MODE(1)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_data(d4), .in_ready(r4o),
    .out_valid(ov4), .out_data(od4), .out_sel(s4), .out_ready(r4));
  rr_arb_mux #(.WIDTH(32), .NUM_IN(4), .RR_MODE(0)) u_fix4 (
    .clk(clk), .rst_n(rst_n), .in_valid(vf), .in_data(df), .in_ready(rfo),
    .out_valid(ovf), .out_data(odf), .out_sel(sf), .out_ready(rf));
  rr_arb_mux #(.WIDTH(32), .NUM_IN(3), .RR_MODE(1)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3), .in_ready(r3o),
    .out_valid(ov3), .out_data(od3), .out_sel(s3), .out_ready(r3));

  typedef struct packed {
    logic [3:0]   v;
    logic [127:0] d;
    logic         r;
    logic [3:0]   rdy;
    logic         ov;
    logic [31:0]  od;
    logic [1:0]   sel;
  } vec_t;

  localparam int NV = 19;
  vec_t tv [NV];
  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [127:0] dat4(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] dd;
    logic [1:0]   e3 [5];
    dd = dat4(32'h10, 32'h11, 32'h12, 32'h13);
    for (int i = 0; i < 8; i++)
      tv[i] = '{4'hF, dd, 1'b1, 4'(1 << (i % 4)), 1'b1, 32'h10 + 32'(i % 4), 2'(i % 4)};
    tv[8]  = '{4'b0100, dat4(32'h10, 32'h11, 32'hDEADBEEF, 32'h13), 1'b1, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2};
    tv[9]  = '{4'b0000, dd, 1'b1, 4'b0000, 1'b0, 32'hDEADBEEF, 2'd2};
    tv[10] = '{4'b0011, dd, 1'b1, 4'b0001, 1'b1, 32'h10, 2'd0};
    tv[11] = '{4'b0011, dd, 1'b0, 4'b0000, 1'b1, 32'h10, 2'd0};
    tv[12] = '{4'b0011, dd, 1'b0, 4'b0000, 1'b1, 32'h10, 2'd0};
    tv[13] = '{4'b0011, dd, 1'b0, 4'b0000, 1'b1, 32'h10, 2'd0};
    tv[14] = '{4'b0011, dd, 1'b1, 4'b0010, 1'b1, 32'h11, 2'd1};
    tv[15] = '{4'b1001, dd, 1'b1, 4'b1000, 1'b1, 32'h13, 2'd3};
    tv[16] = '{4'b1001, dd, 1'b1, 4'b0001, 1'b1, 32'h10, 2'd0};
    tv[17] = '{4'b0000, dd, 1'b0, 4'b0000, 1'b1, 32'h10, 2'd0};
    tv[18] = '{4'b0000, dd, 1'b1, 4'b0000, 1'b0, 32'h10, 2'd0};

    rst_n = 1'b0;
    v4 = 4'hF; d4 = dd; r4 = 1'b1;
    vf = 4'h0; df = dat4(32'h20, 32'h21, 32'h22, 32'h23); rf = 1'b1;
    v3 = 3'h0; d3 = {32'h32, 32'h31, 32'h30}; r3 = 1'b1;
    #3;
    chk("reset_out_valid", 32'(ov4), 32'd0);
    chk("reset_out_data", od4, 32'd0);
    chk("reset_out_sel", 32'(s4), 32'd0);
    chk("reset_in_ready", 32'(r4o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v4 = 4'h0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      v4 = tv[i].v; d4 = tv[i].d; r4 = tv[i].r;
      #1 chk($sformatf("rr4_in_ready[%0d]", i), 32'(r4o), 32'(tv[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("rr4_out_valid[%0d]", i), 32'(ov4), 32'(tv[i].ov));
      chk($sformatf("rr4_out_data[%0d]", i), od4, tv[i].od);
      chk($sformatf("rr4_out_sel[%0d]", i), 32'(s4), 32'(tv[i].sel));
    end

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vf = (i == 5) ? 4'b1100 : 4'b1010;
      #1 chk($sformatf("fix_in_ready[%0d]", i), 32'(rfo), (i == 5) ? 32'b0100 : 32'b0010);
      @(posedge clk);
      #1;
      chk($sformatf("fix_out_valid[%0d]", i), 32'(ovf), 32'd1);
      chk($sformatf("fix_out_data[%0d]", i), odf, (i == 5) ? 32'h22 : 32'h21);
      chk($sformatf("fix_out_sel[%0d]", i), 32'(sf), (i == 5) ? 32'd2 : 32'd1);
    end
    @(negedge clk);
    vf = 4'h0;

    e3 = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v3 = 3'b111;
      #1 chk($sformatf("rr3_in_ready[%0d]", i), 32'(r3o), 32'(1) << e3[i]);
      @(posedge clk);
      #1;
      chk($sformatf("rr3_out_valid[%0d]", i), 32'(ov3), 32'd1);
      chk($sformatf("rr3_out_data[%0d]", i), od3, 32'h30 + 32'(e3[i]));
      chk($sformatf("rr3_out_sel[%0d]", i), 32'(s3), 32'(e3[i]));
    end
    @(negedge clk);
    v3 = 3'h0;

    @(negedge clk);
    v4 = 4'b0001; d4 = dat4(32'h55, 32'h11, 32'h12, 32'h13); r4 = 1'b1;
    #1 chk("pre_rst_in_ready", 32'(r4o), 32'b0001);
    @(posedge clk);
    #1;
    chk("pre_rst_out_valid", 32'(ov4), 32'd1);
    chk("pre_rst_out_data", od4, 32'h55);
    @(negedge clk);
    r4 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(ov4), 32'd0);
    chk("async_rst_out_data", od4, 32'd0);
    chk("async_rst_out_sel", 32'(s4), 32'd0);
    chk("async_rst_in_ready", 32'(r4o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v4 = 4'h0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
